// File: rtl/systolic_requant_drain_pkg.sv
// Shared requantization helpers: saturation bounds, round-half-up shift, per-row config.
// Reused by other requant consumers such as pooling.
package systolic_requant_drain_pkg;

  typedef struct packed {
    logic [4:0] shift;
    logic       relu;
  } requant_cfg_t;

  function automatic logic signed [63:0] sat_max(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

  // Round half up, then arithmetic shift; 64-bit headroom keeps the bias add from wrapping.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] s,
                                                     input logic [4:0]         sh);
    if (sh == 5'd0) return s;
    return (s + (64'sd1 <<< (sh - 5'd1))) >>> sh;
  endfunction

endpackage

// File: rtl/systolic_requant_drain_sync_fifo.sv
// Row FIFO with one extra pointer bit so full and empty differ only in the MSB.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module systolic_requant_drain_sync_fifo
  #(parameter int DEPTH = 4,
    parameter int WIDTH = 36)
  (input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/systolic_requant_drain.sv
// Drain for the systolic core: bias add (S1), round/shift/ReLU/saturate (S2), row FIFO.
// The core cannot be stalled, so rows arriving at a full FIFO are dropped and counted.
module systolic_requant_drain
  import systolic_requant_drain_pkg::*;
  #(parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4)
  (input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N-1:0]                  valid_in,
   input  logic [N*ACC_WIDTH-1:0]        y_in,
   input  logic [N*ACC_WIDTH-1:0]        bias,
   input  logic [4:0]                    cfg_shift,
   input  logic                          cfg_relu,
   input  logic                          clr_ovf,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [N*DATA_WIDTH-1:0]       m_data,
   output logic [N-1:0]                  m_mask,
   output logic [$clog2(FIFO_DEPTH):0]   fill,
   output logic                          overflow,
   output logic [15:0]                   drop_cnt);

  localparam int SW = ACC_WIDTH + 2;
  localparam int DW = N * DATA_WIDTH;
  localparam int FW = DW + N;

  logic              s1_valid;
  logic [N-1:0]      s1_mask;
  requant_cfg_t      s1_cfg;
  logic [N*SW-1:0]   s1_sum;
  logic [N*SW-1:0]   sum_next;

  logic              s2_valid;
  logic [FW-1:0]     s2_row;
  logic [DW-1:0]     rq_next;

  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;

  function automatic logic [DATA_WIDTH-1:0] requant(input logic [SW-1:0] s,
                                                     input requant_cfg_t cfg);
    logic signed [63:0] r;
    r = round_shift($signed({{(64-SW){s[SW-1]}}, s}), cfg.shift);
    if (cfg.relu && r < 64'sd0) r = '0;
    if (r > sat_max(DATA_WIDTH))      r = sat_max(DATA_WIDTH);
    else if (r < sat_min(DATA_WIDTH)) r = sat_min(DATA_WIDTH);
    return r[DATA_WIDTH-1:0];
  endfunction

  // Two guard bits make the sum exact for any y/bias pair.
  always_comb begin
    sum_next = '0;
    for (int j = 0; j < N; j++) begin
      sum_next[j*SW +: SW] =
          {{2{y_in[j*ACC_WIDTH+ACC_WIDTH-1]}}, y_in[j*ACC_WIDTH +: ACC_WIDTH]} +
          {{2{bias[j*ACC_WIDTH+ACC_WIDTH-1]}}, bias[j*ACC_WIDTH +: ACC_WIDTH]};
    end
  end

  always_comb begin
    rq_next = '0;
    for (int j = 0; j < N; j++) begin
      if (s1_mask[j]) rq_next[j*DATA_WIDTH +: DATA_WIDTH] = requant(s1_sum[j*SW +: SW], s1_cfg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mask  <= '0;
      s1_cfg   <= '0;
      s1_sum   <= '0;
      s2_valid <= 1'b0;
      s2_row   <= '0;
    end else begin
      s1_valid     <= |valid_in;
      s1_mask      <= valid_in;
      s1_cfg.shift <= cfg_shift;
      s1_cfg.relu  <= cfg_relu;
      s1_sum       <= sum_next;
      s2_valid     <= s1_valid;
      s2_row       <= {s1_mask, rq_next};
    end
  end

  systolic_requant_drain_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s2_valid),
    .pop   (pop),
    .wdata (s2_row),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill)
  );

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_data  = fifo_rdata[DW-1:0];
  assign m_mask  = fifo_rdata[FW-1:DW];
  assign drop    = s2_valid && fifo_full && !pop;

  // A drop in the same cycle as a clear wins, so the new count starts at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_systolic_requant_drain.sv
// Self-checking bench: constant vectors, hand sequences for overflow/full/reset, random vs. queue model.
module tb_systolic_requant_drain;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    valid_in;
  logic [N*AW-1:0] y_in;
  logic [N*AW-1:0] bias;
  logic [4:0]      cfg_shift;
  logic            cfg_relu;
  logic            clr_ovf;
  logic            m_valid;
  logic            m_ready;
  logic [N*DW-1:0] m_data;
  logic [N-1:0]    m_mask;
  logic [2:0]      fill;
  logic            overflow;
  logic [15:0]     drop_cnt;

  always #5 clk = ~clk;

  systolic_requant_drain #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .y_in      (y_in),
    .bias      (bias),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .clr_ovf   (clr_ovf),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_mask    (m_mask),
    .fill      (fill),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic [N*DW-1:0] data;
    logic [N-1:0]    mask;
  } row_t;

  typedef struct {
    logic [N-1:0]    vin;
    logic [N*AW-1:0] y;
    logic [N*AW-1:0] b;
    logic [4:0]      sh;
    logic            relu;
    logic [N*DW-1:0] exp_data;
    logic [N-1:0]    exp_mask;
  } vec_t;

  row_t q[$];
  row_t p1, p2;
  bit   p1v, p2v;
  bit   mo;
  int   mcnt;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*AW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {AW'(d), AW'(c), AW'(b), AW'(a)};
  endfunction

  function automatic logic [N*DW-1:0] pack8(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  // Reference requant: exact integer arithmetic with floor division.
  function automatic row_t model_row(input logic [N-1:0] vin, input logic [N*AW-1:0] yv,
                                     input logic [N*AW-1:0] bv, input int sh, input bit relu);
    row_t   r;
    longint s, d, v, qt;
    r.mask = vin;
    r.data = '0;
    for (int j = 0; j < N; j++) begin
      if (vin[j]) begin
        s = longint'($signed(yv[j*AW +: AW])) + longint'($signed(bv[j*AW +: AW]));
        if (sh == 0) qt = s;
        else begin
          d  = longint'(1) << sh;
          v  = s + d / 2;
          qt = v / d;
          if ((v % d != 0) && (v < 0)) qt = qt - 1;
        end
        if (relu && qt < 0) qt = 0;
        if (qt > 127)  qt = 127;
        if (qt < -128) qt = -128;
        r.data[j*DW +: DW] = qt[7:0];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    p1v  = 0;
    p2v  = 0;
    mo   = 0;
    mcnt = 0;
  endtask

  task automatic compare_model();
    check("m_valid", m_valid, q.size() > 0);
    check("fill", fill, q.size());
    check("overflow", overflow, mo);
    check("drop_cnt", drop_cnt, mcnt);
    if (q.size() > 0) begin
      check("m_data", m_data, q[0].data);
      check("m_mask", m_mask, q[0].mask);
    end
  endtask

  // Drive one cycle, advance the model by one edge, then compare at the falling edge.
  task automatic step(input logic [N-1:0] vin, input logic [N*AW-1:0] yv,
                      input logic rdy, input logic clr);
    bit dropped;
    valid_in = vin;
    y_in     = yv;
    m_ready  = rdy;
    clr_ovf  = clr;
    if (rdy && q.size() > 0) void'(q.pop_front());
    dropped = 0;
    if (p2v) begin
      if (q.size() < DEPTH) q.push_back(p2);
      else dropped = 1;
    end
    if (dropped) begin
      mo   = 1;
      mcnt = clr ? 1 : ((mcnt == 65535) ? mcnt : mcnt + 1);
    end else if (clr) begin
      mo   = 0;
      mcnt = 0;
    end
    p2  = p1;
    p2v = p1v;
    p1  = model_row(vin, yv, bias, cfg_shift, cfg_relu);
    p1v = |vin;
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  vec_t        tbl[7];
  logic [7:0]  got[$];
  logic [N-1:0] rv;
  logic [N*AW-1:0] ry;

  initial begin
    tbl[0] = '{4'hF, pack4(100, 300, -300, -128), '0, 5'd0, 1'b0, pack8(100, 127, -128, -128), 4'hF};
    tbl[1] = '{4'hF, pack4(10, -10, 6, -6), '0, 5'd2, 1'b0, pack8(3, -2, 2, -1), 4'hF};
    tbl[2] = '{4'hF, pack4(10, 10, 10, 10), pack4(2, 2, 2, 2), 5'd2, 1'b0, pack8(3, 3, 3, 3), 4'hF};
    tbl[3] = '{4'hF, pack4(-5, 5, 0, -1), '0, 5'd0, 1'b1, pack8(0, 5, 0, 0), 4'hF};
    tbl[4] = '{4'b0101, pack4(7, 7, 7, 7), '0, 5'd0, 1'b0, pack8(7, 0, 7, 0), 4'b0101};
    tbl[5] = '{4'hF, pack4(32'h7fffffff, 32'h80000000, 100, -1),
               pack4(32'h7fffffff, 32'h80000000, 0, 0), 5'd31, 1'b0, pack8(2, -2, 0, 0), 4'hF};
    tbl[6] = '{4'hF, pack4(1000, -1000, 127, 128), '0, 5'd0, 1'b1, pack8(127, 0, 127, 127), 4'hF};

    rst_n = 1'b0; valid_in = '0; y_in = '0; bias = '0; cfg_shift = '0;
    cfg_relu = 1'b0; clr_ovf = 1'b0; m_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_fill", fill, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_mask", m_mask, 0);
    rst_n = 1'b1;

    // Constant vectors: each row must appear exactly three edges after it is driven.
    for (int i = 0; i < 7; i++) begin
      bias = tbl[i].b; cfg_shift = tbl[i].sh; cfg_relu = tbl[i].relu;
      step(tbl[i].vin, tbl[i].y, 1'b1, 1'b0);
      step('0, '0, 1'b1, 1'b0);
      check("vec_lat_early", m_valid, 0);
      step('0, '0, 1'b1, 1'b0);
      check("vec_lat_valid", m_valid, 1);
      check("vec_data", m_data, tbl[i].exp_data);
      check("vec_mask", m_mask, tbl[i].exp_mask);
      step('0, '0, 1'b1, 1'b0);
    end

    // Overflow: five rows into a stalled consumer.
    bias = '0; cfg_shift = '0; cfg_relu = 1'b0;
    for (int t = 1; t <= 5; t++) step(4'hF, pack4(t, 0, 0, 0), 1'b0, 1'b0);
    repeat (3) step('0, '0, 1'b0, 1'b0);
    check("ovf_fill", fill, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_cnt", drop_cnt, 1);
    // Sixth row dropped on the same edge as a clear: the drop wins.
    step(4'hF, pack4(6, 0, 0, 0), 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b1);
    check("clr_drop_flag", overflow, 1);
    check("clr_drop_cnt", drop_cnt, 1);
    got.delete();
    for (int k = 0; k < 6; k++) begin
      if (m_valid) got.push_back(m_data[7:0]);
      step('0, '0, 1'b1, 1'b0);
    end
    check("drain_count", got.size(), 4);
    for (int k = 0; k < got.size(); k++) check("drain_order", got[k], k + 1);
    check("drain_fill", fill, 0);
    step('0, '0, 1'b0, 1'b1);
    check("clr_flag", overflow, 0);
    check("clr_cnt", drop_cnt, 0);

    // Push and pop together at full: occupancy holds at four, nothing dropped.
    for (int s = 1; s <= 14; s++) begin
      step((s == 5 || s == 6) ? 4'h0 : 4'hF, pack4(10 + s, 0, 0, 0), s >= 9, 1'b0);
      if (s >= 9) begin
        check("full_pp_fill", fill, 4);
        check("full_pp_cnt", drop_cnt, 0);
      end
    end

    // Reset mid-stream with rows in flight and buffered.
    rst_n = 1'b0; valid_in = '0; m_ready = 1'b0;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_fill", fill, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_overflow", overflow, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'hF, pack4(42, 0, 0, 0), 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("post_rst_early", m_valid, 0);
    step('0, '0, 1'b0, 1'b0);
    check("post_rst_valid", m_valid, 1);
    check("post_rst_data", m_data[7:0], 42);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0)
        for (int j = 0; j < N; j++)
          bias[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? $urandom : AW'($urandom_range(0, 200)) - 32'd100;
      cfg_shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      cfg_relu  = $urandom_range(0, 3) == 0;
      rv = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      for (int j = 0; j < N; j++)
        ry[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? $urandom : AW'($urandom_range(0, 1200)) - 32'd600;
      step(rv, ry, $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
